// File: rtl/hqm_aw_lifo_prefetch.sv
// Prefetch buffer in front of a LIFO: keeps a small register FIFO topped up with popped entries for an alloc client
// and pushes freed entries back. Optional parity check at capture enabled by HQM_AW_LIFO_PREFETCH_PAR_CHK_EN.
module hqm_aw_lifo_prefetch #(
    parameter int DWIDTH   = 16,
    parameter int PF_DEPTH = 4,
    parameter int RD_LAT   = 2,
    parameter int PFB2P1   = $clog2(PF_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_pf_en,
    output logic              lifo_pop,
    input  logic [DWIDTH-1:0] lifo_pop_data,
    input  logic              lifo_empty,
    output logic              lifo_push,
    output logic [DWIDTH-1:0] lifo_push_data,
    input  logic              lifo_full,
    output logic              alloc_v,
    output logic [DWIDTH-1:0] alloc_data,
    input  logic              alloc_ready,
    input  logic              free_v,
    input  logic [DWIDTH-1:0] free_data,
    output logic              free_ready,
    output logic              status_idle,
    output logic [PFB2P1-1:0] status_pf_cnt,
    output logic [PFB2P1-1:0] status_inflight,
    output logic              error_of,
    output logic              error_par
);

    localparam int PTRW = $clog2(PF_DEPTH);
    localparam logic [PFB2P1-1:0] DEPTH_C   = PFB2P1'(PF_DEPTH);
    localparam logic [PFB2P1:0]   DEPTH_SUM = (PFB2P1 + 1)'(PF_DEPTH);
    localparam logic [PTRW-1:0]   PTR_LAST  = PTRW'(PF_DEPTH - 1);

    logic [DWIDTH-1:0] buf_r [PF_DEPTH];
    logic [PTRW-1:0]   head_r;
    logic [PTRW-1:0]   tail_r;
    logic [PFB2P1-1:0] pf_cnt_r;
    logic [PFB2P1-1:0] inflight_r;
    logic [RD_LAT-1:0] lat_sr_r;
    logic [PFB2P1-1:0] pf_cnt_nxt_s;
    logic [PFB2P1-1:0] inflight_nxt_s;
    logic [PFB2P1:0]   occ_sum_s;
    logic              capture_s;
    logic              deq_s;
    logic              ovf_s;
    logic              wr_s;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTR_LAST) ? {PTRW{1'b0}} : p + PTRW'(1);
    endfunction

    // Occupancy counted at one extra bit so buffered + in-flight never wraps.
    assign occ_sum_s = {1'b0, pf_cnt_r} + {1'b0, inflight_r};
    assign lifo_pop  = cfg_pf_en & ~lifo_empty & (occ_sum_s < DEPTH_SUM);

    assign capture_s = lat_sr_r[RD_LAT-1];
    assign alloc_v   = (pf_cnt_r != {PFB2P1{1'b0}});
    assign deq_s     = alloc_v & alloc_ready;
    assign ovf_s     = capture_s & (pf_cnt_r == DEPTH_C) & ~deq_s;
    assign wr_s      = capture_s & ~ovf_s;

    assign alloc_data     = buf_r[head_r];
    assign free_ready     = ~lifo_full;
    assign lifo_push      = free_v & ~lifo_full;
    assign lifo_push_data = free_data;

    assign status_idle     = (inflight_r == {PFB2P1{1'b0}}) & ~free_v;
    assign status_pf_cnt   = pf_cnt_r;
    assign status_inflight = inflight_r;
    assign error_of        = ovf_s;

`ifdef HQM_AW_LIFO_PREFETCH_PAR_CHK_EN
    function automatic logic par_calc(input logic [DWIDTH-2:0] d);
        return ^d;
    endfunction

    assign error_par = capture_s & (lifo_pop_data[DWIDTH-1] != par_calc(lifo_pop_data[DWIDTH-2:0]));
`else
    assign error_par = 1'b0;
`endif

    // Buffer occupancy: capture adds, dequeue removes, a dropped overflow capture adds nothing.
    always_comb begin
        pf_cnt_nxt_s = pf_cnt_r;
        case ({wr_s, deq_s})
            2'b10:   pf_cnt_nxt_s = pf_cnt_r + PFB2P1'(1);
            2'b01:   pf_cnt_nxt_s = pf_cnt_r - PFB2P1'(1);
            default: pf_cnt_nxt_s = pf_cnt_r;
        endcase
    end

    // In-flight pop count mirrors the population of the latency shift register.
    always_comb begin
        inflight_nxt_s = inflight_r;
        case ({lifo_pop, capture_s})
            2'b10:   inflight_nxt_s = inflight_r + PFB2P1'(1);
            2'b01:   inflight_nxt_s = inflight_r - PFB2P1'(1);
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // Read-latency tracker: a pop enters stage 0 and emerges as the capture strobe RD_LAT cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_sr_r   <= {RD_LAT{1'b0}};
            inflight_r <= {PFB2P1{1'b0}};
        end else begin
            lat_sr_r[0] <= lifo_pop;
            for (int i = 1; i < RD_LAT; i++) begin
                lat_sr_r[i] <= lat_sr_r[i-1];
            end
            inflight_r <= inflight_nxt_s;
        end
    end

    // Circular prefetch buffer storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r   <= {PTRW{1'b0}};
            tail_r   <= {PTRW{1'b0}};
            pf_cnt_r <= {PFB2P1{1'b0}};
            for (int i = 0; i < PF_DEPTH; i++) begin
                buf_r[i] <= {DWIDTH{1'b0}};
            end
        end else begin
            if (wr_s) begin
                buf_r[tail_r] <= lifo_pop_data;
                tail_r        <= ptr_inc(tail_r);
            end
            if (deq_s) begin
                head_r <= ptr_inc(head_r);
            end
            pf_cnt_r <= pf_cnt_nxt_s;
        end
    end

endmodule
